// File: rtl/load_store_unit_pkg.sv
// lsu_pkg: shared types and helpers for the load/store unit.
//   mem_op_t     - memory operation encoding presented on req_op
//   lsu_state_t  - sequencing states of the unit
//   is_load      - true for the five load operations
//   is_misaligned- true when the byte offset violates the natural alignment of op
package lsu_pkg;

    typedef enum logic [2:0] {
        LD_B  = 3'd0,
        LD_H  = 3'd1,
        LD_W  = 3'd2,
        LD_BU = 3'd3,
        LD_HU = 3'd4,
        ST_B  = 3'd5,
        ST_H  = 3'd6,
        ST_W  = 3'd7
    } mem_op_t;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'd0,
        LSU_ACCESS = 2'd1,
        LSU_WRITE  = 2'd2,
        LSU_RESP   = 2'd3
    } lsu_state_t;

    function automatic logic is_load(input mem_op_t op);
        logic ld;
        case (op)
            LD_B, LD_H, LD_W, LD_BU, LD_HU: ld = 1'b1;
            default:                        ld = 1'b0;
        endcase
        return ld;
    endfunction

    function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] off);
        logic mis;
        case (op)
            LD_H, LD_HU, ST_H: mis = off[0];
            LD_W, ST_W:        mis = (off != 2'b00);
            default:           mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response handshake plus the word-wide RAM port.
//   req_*  : request from execute (valid/ready), op, byte address, store data
//   resp_* : one-cycle completion pulse with load data and alignment error
//   ram_*  : word address, write data, write enable and async read data
//   master : the side issuing requests and modelling the RAM
//   slave  : the load/store unit
interface load_store_unit_if
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    mem_op_t           req_op;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_ale;
    logic [ADDR_W-3:0] ram_a;
    logic [31:0]       ram_d;
    logic              ram_we;
    logic [31:0]       ram_spo;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, ram_spo,
        input  req_ready, resp_valid, resp_rdata, resp_ale, ram_a, ram_d, ram_we
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, ram_spo,
        output req_ready, resp_valid, resp_rdata, resp_ale, ram_a, ram_d, ram_we
    );
endinterface

// File: rtl/load_store_unit_mem_lane_align.sv
// mem_lane_align: combinational lane steering for the load/store unit.
//   op       : memory operation
//   off      : byte offset within the word (addr[1:0])
//   ld_word  : word read from RAM for a load
//   old_word : previously read word for a sub-word store
//   st_data  : store data (low byte / low halfword used for ST_B / ST_H)
//   ld_data  : extracted and sign/zero-extended load result
//   st_word  : old_word with the addressed lane(s) replaced
module mem_lane_align
    import lsu_pkg::*;
(
    input  mem_op_t     op,
    input  logic [1:0]  off,
    input  logic [31:0] ld_word,
    input  logic [31:0] old_word,
    input  logic [31:0] st_data,
    output logic [31:0] ld_data,
    output logic [31:0] st_word
);
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Load extract and extend; little-endian, lane n is bits [8n+7:8n].
    always_comb begin
        case (off)
            2'd0:    byte_s = ld_word[7:0];
            2'd1:    byte_s = ld_word[15:8];
            2'd2:    byte_s = ld_word[23:16];
            2'd3:    byte_s = ld_word[31:24];
            default: byte_s = 8'd0;
        endcase
        if (off[1]) begin
            half_s = ld_word[31:16];
        end else begin
            half_s = ld_word[15:0];
        end
        case (op)
            LD_B:    ld_data = {{24{byte_s[7]}}, byte_s};
            LD_BU:   ld_data = {24'd0, byte_s};
            LD_H:    ld_data = {{16{half_s[15]}}, half_s};
            LD_HU:   ld_data = {16'd0, half_s};
            LD_W:    ld_data = ld_word;
            default: ld_data = 32'd0;
        endcase
    end

    // Store merge: replace only the addressed lane(s) of the old word.
    always_comb begin
        st_word = old_word;
        case (op)
            ST_B: begin
                case (off)
                    2'd0:    st_word[7:0]   = st_data[7:0];
                    2'd1:    st_word[15:8]  = st_data[7:0];
                    2'd2:    st_word[23:16] = st_data[7:0];
                    2'd3:    st_word[31:24] = st_data[7:0];
                    default: st_word        = old_word;
                endcase
            end
            ST_H: begin
                if (off[1]) begin
                    st_word[31:16] = st_data[15:0];
                end else begin
                    st_word[15:0]  = st_data[15:0];
                end
            end
            ST_W:    st_word = st_data;
            default: st_word = old_word;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle LA32R load/store unit in front of a word RAM.
//   clk, rst : core clock, synchronous active-high reset
//   bus      : load_store_unit_if.slave (request/response handshake, RAM port)
// One request at a time. Loads and ST_W take one RAM cycle; ST_B/ST_H read
// the old word then write the merged word. Misaligned requests skip the RAM.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    load_store_unit_if.slave   bus
);
    lsu_state_t        state_q, state_d;
    mem_op_t           op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       old_q, old_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              ale_q, ale_d;

    logic [31:0]       ld_data_s;
    logic [31:0]       st_word_s;
    logic              ram_we_s;
    logic [31:0]       ram_d_s;
    logic              req_mis_s;
    logic              sub_store_s;

    assign req_mis_s   = is_misaligned(bus.req_op, bus.req_addr[1:0]);
    assign sub_store_s = (op_q == ST_B) || (op_q == ST_H);

    mem_lane_align u_align (
        .op       (op_q),
        .off      (addr_q[1:0]),
        .ld_word  (bus.ram_spo),
        .old_word (old_q),
        .st_data  (wdata_q),
        .ld_data  (ld_data_s),
        .st_word  (st_word_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LSU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LSU_IDLE: begin
                if (bus.req_valid) begin
                    state_d = req_mis_s ? LSU_RESP : LSU_ACCESS;
                end else begin
                    state_d = LSU_IDLE;
                end
            end
            LSU_ACCESS: state_d = sub_store_s ? LSU_WRITE : LSU_RESP;
            LSU_WRITE:  state_d = LSU_RESP;
            LSU_RESP:   state_d = LSU_IDLE;
            default:    state_d = LSU_IDLE;
        endcase
    end

    // Request latch, load result and old-word capture.
    always_comb begin
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        old_d   = old_q;
        rdata_d = rdata_q;
        ale_d   = ale_q;
        case (state_q)
            LSU_IDLE: begin
                if (bus.req_valid) begin
                    op_d    = bus.req_op;
                    addr_d  = bus.req_addr[ADDR_W-1:0];
                    wdata_d = bus.req_wdata;
                    ale_d   = req_mis_s;
                    rdata_d = 32'd0;
                end else begin
                    op_d    = op_q;
                end
            end
            LSU_ACCESS: begin
                if (is_load(op_q)) begin
                    rdata_d = ld_data_s;
                end else if (sub_store_s) begin
                    old_d   = bus.ram_spo;
                end else begin
                    rdata_d = 32'd0;
                end
            end
            default: begin
                ale_d = ale_q;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= LD_B;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            old_q   <= 32'd0;
            rdata_q <= 32'd0;
            ale_q   <= 1'b0;
        end else begin
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            old_q   <= old_d;
            rdata_q <= rdata_d;
            ale_q   <= ale_d;
        end
    end

    // RAM write decode from registered state only.
    always_comb begin
        ram_we_s = 1'b0;
        ram_d_s  = 32'd0;
        case (state_q)
            LSU_ACCESS: begin
                if (op_q == ST_W) begin
                    ram_we_s = 1'b1;
                    ram_d_s  = wdata_q;
                end else begin
                    ram_we_s = 1'b0;
                end
            end
            LSU_WRITE: begin
                ram_we_s = 1'b1;
                ram_d_s  = st_word_s;
            end
            default: begin
                ram_we_s = 1'b0;
            end
        endcase
    end

    // rst overrides the decoded strobes so an aborted access never writes or responds.
    assign bus.ram_we     = ram_we_s & ~rst;
    assign bus.ram_d      = ram_d_s;
    assign bus.ram_a      = addr_q[ADDR_W-1:2];
    assign bus.req_ready  = (state_q == LSU_IDLE);
    assign bus.resp_valid = (state_q == LSU_RESP) & ~rst;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_ale   = ale_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vectors with hand-computed expectations for
// load_store_unit, plus a small behavioural word RAM.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    load_store_unit_if #(.ADDR_W(16)) bus ();

    load_store_unit #(.ADDR_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:63];
    assign bus.ram_spo = mem[bus.ram_a[5:0]];

    always @(posedge clk) begin
        if (bus.ram_we) begin
            mem[bus.ram_a[5:0]] <= bus.ram_d;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request from a negedge with the unit idle, observe 5 cycles.
    task automatic run_op(input mem_op_t op, input logic [31:0] addr, input logic [31:0] wdata,
                          output int resp_cyc, output int we_cnt, output int we_cyc,
                          output logic [31:0] we_data, output logic [31:0] we_addr,
                          output logic [31:0] rdata, output logic [31:0] ale);
        resp_cyc = 0; we_cnt = 0; we_cyc = 0;
        we_data = 32'd0; we_addr = 32'd0; rdata = 32'hFFFF_FFFF; ale = 32'd9;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (bus.ram_we) begin
                we_cnt++;
                we_cyc  = c;
                we_data = bus.ram_d;
                we_addr = {18'd0, bus.ram_a};
            end
            if (bus.resp_valid && resp_cyc == 0) begin
                resp_cyc = c;
                rdata    = bus.resp_rdata;
                ale      = {31'd0, bus.resp_ale};
            end
        end
    endtask

    typedef struct {
        mem_op_t     op;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          exp_resp;
        int          exp_we;
        int          exp_we_cyc;
        logic [31:0] exp_we_data;
        logic [31:0] exp_rdata;
        logic [31:0] exp_ale;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int          rc, wc, wcy, n_acc, we_q, resp_q;
        int          acc_cyc [2];
        logic [31:0] wd, wa, rd, al, b_rdata;

        vecs[0]  = '{ST_W,  32'h10, 32'hDEADBEEF, 2, 1, 1, 32'hDEADBEEF, 32'h0, 32'h0};
        vecs[1]  = '{LD_B,  32'h13, 32'h0,        2, 0, 0, 32'h0, 32'hFFFFFFDE, 32'h0};
        vecs[2]  = '{LD_BU, 32'h13, 32'h0,        2, 0, 0, 32'h0, 32'h000000DE, 32'h0};
        vecs[3]  = '{LD_H,  32'h12, 32'h0,        2, 0, 0, 32'h0, 32'hFFFFDEAD, 32'h0};
        vecs[4]  = '{LD_HU, 32'h10, 32'h0,        2, 0, 0, 32'h0, 32'h0000BEEF, 32'h0};
        vecs[5]  = '{ST_B,  32'h11, 32'h123456AA, 3, 1, 2, 32'hDEADAAEF, 32'h0, 32'h0};
        vecs[6]  = '{LD_W,  32'h10, 32'h0,        2, 0, 0, 32'h0, 32'hDEADAAEF, 32'h0};
        vecs[7]  = '{LD_W,  32'h12, 32'h0,        1, 0, 0, 32'h0, 32'h0, 32'h1};
        vecs[8]  = '{ST_H,  32'h11, 32'h0000BEEF, 1, 0, 0, 32'h0, 32'h0, 32'h1};
        vecs[9]  = '{ST_H,  32'h12, 32'h0000CAFE, 3, 1, 2, 32'hCAFEAAEF, 32'h0, 32'h0};
        vecs[10] = '{LD_HU, 32'h12, 32'h0,        2, 0, 0, 32'h0, 32'h0000CAFE, 32'h0};

        bus.req_valid = 1'b0;
        bus.req_op    = LD_B;
        bus.req_addr  = 32'd0;
        bus.req_wdata = 32'd0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_ready", {31'd0, bus.req_ready}, 32'd1);
        check_eq("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check_eq("rst_rdata", bus.resp_rdata, 32'd0);
        check_eq("rst_ale", {31'd0, bus.resp_ale}, 32'd0);
        check_eq("rst_we", {31'd0, bus.ram_we}, 32'd0);
        check_eq("rst_ram_a", {18'd0, bus.ram_a}, 32'd0);
        check_eq("rst_ram_d", bus.ram_d, 32'd0);

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].op, vecs[i].addr, vecs[i].wdata, rc, wc, wcy, wd, wa, rd, al);
            check_eq($sformatf("v%0d_resp_cyc", i), rc, vecs[i].exp_resp);
            check_eq($sformatf("v%0d_we_cnt", i), wc, vecs[i].exp_we);
            check_eq($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            check_eq($sformatf("v%0d_ale", i), al, vecs[i].exp_ale);
            if (vecs[i].exp_we != 0) begin
                check_eq($sformatf("v%0d_we_cyc", i), wcy, vecs[i].exp_we_cyc);
                check_eq($sformatf("v%0d_we_data", i), wd, vecs[i].exp_we_data);
                check_eq($sformatf("v%0d_we_addr", i), wa, 32'd4);
            end else begin
                check_eq($sformatf("v%0d_ram_word", i), mem[4],
                         (i < 5) ? 32'hDEADBEEF : 32'hDEADAAEF);
            end
        end

        // ST_H aborted by reset during its ACCESS cycle.
        bus.req_valid = 1'b1;
        bus.req_op    = ST_H;
        bus.req_addr  = 32'h12;
        bus.req_wdata = 32'h00001234;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort_access_we", {31'd0, bus.ram_we}, 32'd0);
        check_eq("abort_access_resp", {31'd0, bus.resp_valid}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("abort_ready", {31'd0, bus.req_ready}, 32'd1);
        check_eq("abort_rdata", bus.resp_rdata, 32'd0);
        check_eq("abort_ale", {31'd0, bus.resp_ale}, 32'd0);
        check_eq("abort_ram_a", {18'd0, bus.ram_a}, 32'd0);
        check_eq("abort_ram_d", bus.ram_d, 32'd0);
        we_q = 0; resp_q = 0;
        for (int c = 0; c < 4; c++) begin
            if (bus.ram_we) we_q++;
            if (bus.resp_valid) resp_q++;
            @(negedge clk);
        end
        check_eq("abort_we_cnt", we_q, 32'd0);
        check_eq("abort_resp_cnt", resp_q, 32'd0);
        check_eq("abort_ram_word", mem[4], 32'hDEADAAEF);

        for (int i = 9; i < 11; i++) begin
            run_op(vecs[i].op, vecs[i].addr, vecs[i].wdata, rc, wc, wcy, wd, wa, rd, al);
            check_eq($sformatf("v%0d_resp_cyc", i), rc, vecs[i].exp_resp);
            check_eq($sformatf("v%0d_we_cnt", i), wc, vecs[i].exp_we);
            check_eq($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            check_eq($sformatf("v%0d_ale", i), al, vecs[i].exp_ale);
            if (vecs[i].exp_we != 0) begin
                check_eq($sformatf("v%0d_we_cyc", i), wcy, vecs[i].exp_we_cyc);
                check_eq($sformatf("v%0d_we_data", i), wd, vecs[i].exp_we_data);
            end else begin
                check_eq($sformatf("v%0d_ram_word", i), mem[4], 32'hCAFEAAEF);
            end
        end

        // Two back-to-back ops with req_valid held high throughout.
        n_acc = 0; we_q = 0; b_rdata = 32'hFFFF_FFFF;
        acc_cyc[0] = 0; acc_cyc[1] = 0;
        bus.req_valid = 1'b1;
        bus.req_op    = ST_W;
        bus.req_addr  = 32'h20;
        bus.req_wdata = 32'h11223344;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (bus.req_valid && bus.req_ready) begin
                if (n_acc < 2) acc_cyc[n_acc] = cyc;
                n_acc++;
            end
            if (bus.ram_we) we_q++;
            if (bus.resp_valid && n_acc == 2) b_rdata = bus.resp_rdata;
            @(posedge clk);
            #1;
            if (n_acc == 1) begin
                bus.req_op    = LD_B;
                bus.req_addr  = 32'h21;
                bus.req_wdata = 32'd0;
            end else if (n_acc >= 2) begin
                bus.req_valid = 1'b0;
            end else begin
                bus.req_valid = 1'b1;
            end
            @(negedge clk);
        end
        check_eq("queue_accepts", n_acc, 32'd2);
        check_eq("queue_spacing", acc_cyc[1] - acc_cyc[0], 32'd3);
        check_eq("queue_we_cnt", we_q, 32'd1);
        check_eq("queue_ld_rdata", b_rdata, 32'h00000033);
        check_eq("queue_ram_word", mem[8], 32'h11223344);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
